// File: rtl/lz77_encoder.sv
// lz77_encoder: streaming LZ77 compressor emitting (code_pos, code_len, char_nxt) triples.
// Define LZ77_ENC_PARALLEL_SEARCH_EN to score all 9 candidates in a single SEARCH cycle.
module lz77_encoder #(
    parameter int WSEARCH = 9,
    parameter int WLOOK = 8,
    parameter int WCHAR = 8,
    parameter logic [WCHAR-1:0] END_SGN = 8'h24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WCHAR-1:0] chardata,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             valid,
    output logic             encode,
    output logic [3:0]       code_pos,
    output logic [2:0]       code_len,
    output logic [WCHAR-1:0] char_nxt,
    output logic             finish
);
    typedef enum logic [1:0] {S_FILL, S_SEARCH, S_EMIT, S_DONE} state_t;
    state_t r_state, w_state_n;
    logic [WCHAR-1:0] r_srch [WSEARCH];
    logic [WCHAR-1:0] r_look [WLOOK];
    logic [WCHAR-1:0] w_e [WSEARCH+WLOOK];
    logic [3:0] r_lcnt, w_lcnt_n, w_fin_pos, r_code_pos;
    logic [2:0] r_cnt, w_lim, w_fin_len, r_code_len;
    logic [WCHAR-1:0] r_char_nxt;
    logic r_eos, w_eos_n, w_acc, w_emit, w_go_search, w_search_last, w_emit_last, w_load;
    logic r_in_ready, r_valid, r_finish, w_in_ready_n, w_valid_n, w_finish_n;

    // w_e is the history stream oldest-first: srch[8..0] followed by look[0..7],
    // so candidate p starts at w_e[8-p] and the lookahead starts at w_e[9].
    function automatic logic [2:0] f_len(input logic [WCHAR-1:0] e [WSEARCH+WLOOK],
                                         input logic [3:0] p, input logic [2:0] lim);
        logic [2:0] n;
        logic run;
        n = '0;
        run = 1'b1;
        for (int j = 0; j < WLOOK-1; j++) begin
            run = run && (3'(j) < lim) && (e[5'(WSEARCH + j)] == e[5'(WSEARCH-1) - 5'(p) + 5'(j)]);
            n = n + 3'(run);
        end
        return n;
    endfunction

    for (genvar g = 0; g < WSEARCH; g++) begin : g_s
        assign w_e[g] = r_srch[WSEARCH-1-g];
    end
    for (genvar g = 0; g < WLOOK; g++) begin : g_l
        assign w_e[WSEARCH+g] = r_look[g];
    end

    assign w_acc       = in_valid && r_in_ready;
    assign w_emit      = r_state == S_EMIT;
    assign w_lcnt_n    = r_lcnt + 4'(w_acc) - 4'(w_emit);
    assign w_eos_n     = r_eos || (w_acc && chardata == END_SGN);
    assign w_go_search = w_lcnt_n == 4'(WLOOK) || (w_eos_n && w_lcnt_n != 4'd0);
    assign w_lim       = r_lcnt >= 4'(WLOOK) ? 3'(WLOOK-1) : 3'(r_lcnt - 4'd1);
    assign w_emit_last = r_cnt == r_code_len;

`ifdef LZ77_ENC_PARALLEL_SEARCH_EN
    logic [2:0] w_plen [WSEARCH];
    for (genvar g = 0; g < WSEARCH; g++) begin : g_p
        assign w_plen[g] = f_len(w_e, 4'(g), w_lim);
    end
    assign w_search_last = 1'b1;
    always_comb begin
        w_fin_pos = '0;
        w_fin_len = '0;
        for (int p = 0; p < WSEARCH; p++) begin
            w_fin_pos = w_plen[p] > w_fin_len ? 4'(p) : w_fin_pos;
            w_fin_len = w_plen[p] > w_fin_len ? w_plen[p] : w_fin_len;
        end
    end
`else
    logic [3:0] r_p, r_best_pos;
    logic [2:0] r_best_len, w_cand_len;
    assign w_cand_len    = f_len(w_e, r_p, w_lim);
    assign w_search_last = r_p == 4'(WSEARCH-1);
    assign w_fin_pos     = w_cand_len > r_best_len ? r_p : r_best_pos;
    assign w_fin_len     = w_cand_len > r_best_len ? w_cand_len : r_best_len;
    always_ff @(posedge clk) begin
        if (reset || r_state != S_SEARCH) begin
            r_p        <= '0;
            r_best_pos <= '0;
            r_best_len <= '0;
        end else begin
            r_p        <= r_p + 4'd1;
            r_best_pos <= w_fin_pos;
            r_best_len <= w_fin_len;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FILL;
        else r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_FILL:   w_state_n = w_go_search ? S_SEARCH : S_FILL;
            S_SEARCH: w_state_n = w_search_last ? S_EMIT : S_SEARCH;
            S_EMIT:   w_state_n = !w_emit_last ? S_EMIT : r_char_nxt == END_SGN ? S_DONE :
                                  w_go_search ? S_SEARCH : S_FILL;
            default:  w_state_n = S_DONE;
        endcase
    end

    // Outputs are registered, so they are derived from the next-cycle state.
    always_comb begin
        w_in_ready_n = !w_eos_n && (w_state_n == S_EMIT ||
                                    (w_state_n == S_FILL && w_lcnt_n < 4'(WLOOK)));
        w_valid_n    = w_state_n == S_EMIT;
        w_finish_n   = w_state_n == S_DONE;
        w_load       = r_state == S_SEARCH && w_search_last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WSEARCH; i++) r_srch[i] <= '0;
            r_lcnt     <= '0;
            r_eos      <= 1'b0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_valid    <= 1'b0;
            r_finish   <= 1'b0;
            r_code_pos <= '0;
            r_code_len <= '0;
            r_char_nxt <= '0;
        end else begin
            if (w_emit) begin
                r_srch[0] <= r_look[0];
                for (int i = 1; i < WSEARCH; i++) r_srch[i] <= r_srch[i-1];
                for (int i = 0; i < WLOOK-1; i++) r_look[i] <= r_look[i+1];
            end
            if (w_acc) r_look[3'(r_lcnt - 4'(w_emit))] <= chardata;
            r_lcnt     <= w_lcnt_n;
            r_eos      <= w_eos_n;
            r_cnt      <= w_emit ? r_cnt + 3'd1 : 3'd0;
            r_in_ready <= w_in_ready_n;
            r_valid    <= w_valid_n;
            r_finish   <= w_finish_n;
            if (w_load) begin
                r_code_pos <= w_fin_pos;
                r_code_len <= w_fin_len;
                r_char_nxt <= r_look[w_fin_len];
            end
        end
    end

    assign in_ready = r_in_ready;
    assign valid    = r_valid;
    assign encode   = r_valid;
    assign code_pos = r_code_pos;
    assign code_len = r_code_len;
    assign char_nxt = r_char_nxt;
    assign finish   = r_finish;
endmodule

// File: tb/tb_lz77_encoder.sv
// tb_lz77_encoder: directed triple tables, mid-EMIT reset and a random round trip through a decoder model.
module tb_lz77_encoder;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] chardata = 8'h00;
    logic       in_ready, valid, encode, finish;
    logic [3:0] code_pos;
    logic [2:0] code_len;
    logic [7:0] char_nxt;

    lz77_encoder dut (
        .clk(clk), .reset(reset), .chardata(chardata), .in_valid(in_valid),
        .in_ready(in_ready), .valid(valid), .encode(encode), .code_pos(code_pos),
        .code_len(code_len), .char_nxt(char_nxt), .finish(finish)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8*12-1:0] str;
        logic [3:0]      slen;
        logic            tog;
        logic [2:0]      ntrip;
        logic [4*15-1:0] trips;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [7:0] src [0:2099];
    int src_len;
    logic [14:0] got [$];
    int post_acc, bad_hold, fin_ok;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] tr(input logic [3:0] p, input logic [2:0] l, input logic [7:0] c);
        return {p, l, c};
    endfunction

    function automatic vec_t mk(input string s, input bit tg, input logic [2:0] n,
                                input logic [14:0] t0, input logic [14:0] t1,
                                input logic [14:0] t2, input logic [14:0] t3);
        vec_t v;
        v = '0;
        for (int i = 0; i < s.len(); i++) v.str[8*i +: 8] = s[i];
        v.slen  = 4'(s.len());
        v.tog   = tg;
        v.ntrip = n;
        v.trips = {t0, t1, t2, t3};
        return v;
    endfunction

    task automatic load(input vec_t v);
        src_len = int'(v.slen);
        for (int i = 0; i < src_len; i++) src[i] = v.str[8*i +: 8];
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_valid"}, 32'(valid), 0);
        chk({tag, "_encode"}, 32'(encode), 0);
        chk({tag, "_code_pos"}, 32'(code_pos), 0);
        chk({tag, "_code_len"}, 32'(code_len), 0);
        chk({tag, "_char_nxt"}, 32'(char_nxt), 0);
        chk({tag, "_finish"}, 32'(finish), 0);
    endtask

    // Drives src (then a stray 'z' forever) and records each triple once, checking it is held code_len+1 cycles.
    task automatic run_case(input bit tog, input int budget, input int stop_len);
        int idx, hold;
        bit acc, pv;
        logic [14:0] cur, now;
        idx = 0; hold = 0; acc = 0; pv = 0; cur = '0;
        got.delete();
        post_acc = 0; bad_hold = 0; fin_ok = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (acc) begin
                if (idx >= src_len) post_acc++;
                idx++;
            end
            now = {code_pos, code_len, char_nxt};
            if (encode !== valid) bad_hold++;
            if (finish) begin
                fin_ok = (pv && !valid && hold == 0) ? 1 : 2;
                break;
            end
            if (stop_len >= 0 && valid && int'(code_len) == stop_len) begin
                fin_ok = 1;
                break;
            end
            if (valid) begin
                if (hold == 0) begin
                    cur = now;
                    got.push_back(now);
                    hold = int'(code_len) + 1;
                end else if (now !== cur) bad_hold++;
                hold--;
            end else if (hold != 0) begin
                bad_hold++;
                hold = 0;
            end
            pv = valid;
            in_valid = !tog || c[0];
            chardata = idx < src_len ? src[idx] : 8'h7a;
            acc = in_valid && in_ready;
        end
        in_valid = 1'b0;
    endtask

    task automatic check_trips(input string tag, input vec_t v);
        chk({tag, "_finish"}, 32'(fin_ok), 1);
        chk({tag, "_ntrip"}, 32'(got.size()), 32'(v.ntrip));
        for (int i = 0; i < int'(v.ntrip); i++)
            chk($sformatf("%s_trip%0d", tag, i), 32'(got.size() > i ? got[i] : 15'h7fff),
                32'(v.trips[15*(3-i) +: 15]));
        chk({tag, "_no_accept_after_eos"}, 32'(post_acc), 0);
        chk({tag, "_hold"}, 32'(bad_hold), 0);
    endtask

    // Reference decoder: copy srch[p] L times then the literal, pushing every output char.
    task automatic decode_check(input string tag);
        logic [7:0] d [9];
        logic [7:0] ch;
        logic [3:0] p;
        int l, k, bad;
        for (int i = 0; i < 9; i++) d[i] = 8'h00;
        k = 0; bad = 0;
        foreach (got[t]) begin
            p = got[t][14:11];
            l = int'(got[t][10:8]);
            for (int j = 0; j <= l; j++) begin
                ch = j < l ? (p < 4'd9 ? d[p] : 8'hff) : got[t][7:0];
                if (k >= src_len || ch !== src[k]) bad++;
                k++;
                for (int s = 8; s > 0; s--) d[s] = d[s-1];
                d[0] = ch;
            end
        end
        chk({tag, "_decode_len"}, 32'(k), 32'(src_len));
        chk({tag, "_decode_data"}, 32'(bad), 0);
    endtask

    initial begin
        vec_t vt [4];
        vt[0] = mk("aab$", 1'b0, 3'd3, tr(0, 0, 8'h61), tr(0, 1, 8'h62), tr(0, 0, 8'h24), 15'h0);
        vt[1] = mk("aaaaaaaaa$", 1'b0, 3'd3, tr(0, 0, 8'h61), tr(0, 7, 8'h61), tr(0, 0, 8'h24), 15'h0);
        vt[2] = mk("abcabc$", 1'b0, 3'd4, tr(0, 0, 8'h61), tr(0, 0, 8'h62), tr(0, 0, 8'h63), tr(2, 3, 8'h24));
        vt[3] = mk("abcabc$", 1'b1, 3'd4, tr(0, 0, 8'h61), tr(0, 0, 8'h62), tr(0, 0, 8'h63), tr(2, 3, 8'h24));

        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        reset = 1'b0;
        @(negedge clk);
        chk("in_ready_rise", 32'(in_ready), 1);

        for (int v = 0; v < 4; v++) begin
            do_reset;
            load(vt[v]);
            run_case(vt[v].tog, 2000, -1);
            check_trips($sformatf("vec%0d", v), vt[v]);
        end

        do_reset;
        load(vt[1]);
        run_case(1'b0, 2000, 7);
        chk("emit7_reached", 32'(fin_ok), 1);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst");
        reset = 1'b0;
        load(vt[0]);
        run_case(1'b0, 2000, -1);
        check_trips("after_rst", vt[0]);

        do_reset;
        src_len = 2048;
        for (int i = 0; i < 2047; i++) src[i] = 8'h61 + 8'($urandom_range(0, 2));
        src[2047] = 8'h24;
        run_case(1'b0, 60000, -1);
        chk("rand_finish", 32'(fin_ok), 1);
        chk("rand_no_accept_after_eos", 32'(post_acc), 0);
        chk("rand_hold", 32'(bad_hold), 0);
        decode_check("rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
